image_fetch_distributor: RTL and testbench

Upstream feeder for the four Otsu processing elements. On start, it streams every pixel of the grayscale image from byte-wide memory, starting at a base address. Pixels are dealt round-robin into four per-lane show-ahead FIFOs (pixel i goes to lane i mod 4); each processing element drains its own lane. Reads stall per lane on FIFO full, and done reports when the whole image has been fetched and consumed.

---
 rtl/otsu_pkg.sv | 16 +
 rtl/lane_fifo.sv | 60 ++++++
 rtl/image_fetch_distributor.sv | 147 ++++++++++++++
 tb/tb_image_fetch_distributor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/otsu_pkg.sv
// rtl/otsu_pkg.sv - shared lane count, fetch-state encoding and default base addresses
package otsu_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_FETCH_BASE_ADDR     = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_WRITEBACK_BASE_ADDR = 32'h0001_0000;

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - synchronous show-ahead FIFO feeding one processing lane
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset (flushes)
//   wr_en, wr_data     push; ignored when full unless the same cycle also pops
//   rd_en              pop head; ignored when empty
//   rd_data            head entry, zero while empty
//   empty, full, count occupancy status
module lane_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop     = rd_en && !empty;
  assign push    = wr_en && (!full || pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; rd_data is gated by empty instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/image_fetch_distributor.sv
// rtl/image_fetch_distributor.sv - streams an image from byte memory round-robin into four lane FIFOs
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   start                       begin a fetch; honoured in IDLE or DONE only
//   done                        high in DONE
//   mem_addr, mem_en, mem_rw    byte read port (mem_rw tied low)
//   mem_data_in                 read data, one cycle after mem_en
//   fifo_data_k, fifo_empty_k   head pixel and empty flag of lane k
//   fifo_rd_en_k                pop lane k
module image_fetch_distributor
  import otsu_pkg::*;
#(
  parameter int          IMAGE_WIDTH  = 64,
  parameter int          IMAGE_HEIGHT = 64,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_FETCH_BASE_ADDR,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  input  logic [7:0]  mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [7:0]  fifo_data_0,
  output logic [7:0]  fifo_data_1,
  output logic [7:0]  fifo_data_2,
  output logic [7:0]  fifo_data_3,
  output logic        fifo_empty_0,
  output logic        fifo_empty_1,
  output logic        fifo_empty_2,
  output logic        fifo_empty_3,
  input  logic        fifo_rd_en_0,
  input  logic        fifo_rd_en_1,
  input  logic        fifo_rd_en_2,
  input  logic        fifo_rd_en_3
);

  localparam int TOTAL_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CNT_W        = $clog2(TOTAL_PIXELS + 1);
  localparam int FIFO_CNT_W   = $clog2(FIFO_DEPTH + 1);

  fetch_state_t           state;
  logic [CNT_W-1:0]       issue_cnt;
  logic [CNT_W-1:0]       write_cnt;
  logic [1:0]             issue_lane;
  logic [1:0]             inflight_lane;
  logic                   inflight_valid;

  logic [NUM_LANES-1:0]   rd_en_vec;
  logic [NUM_LANES-1:0]   pop_vec;
  logic [NUM_LANES-1:0]   wr_en_vec;
  logic [NUM_LANES-1:0]   empty_vec;
  logic [NUM_LANES-1:0]   full_vec;
  logic [7:0]             rd_data_arr [NUM_LANES];
  logic [FIFO_CNT_W-1:0]  count_arr   [NUM_LANES];

  logic                   issue;
  logic                   last_issue;
  logic                   all_drained;

  assign rd_en_vec = {fifo_rd_en_3, fifo_rd_en_2, fifo_rd_en_1, fifo_rd_en_0};
  assign pop_vec   = rd_en_vec & ~empty_vec;

  // A full lane still accepts an issue when it is popped this cycle: the
  // byte lands a cycle later, after the pop has freed the slot.
  assign issue      = (state == FETCH) && (!full_vec[issue_lane] || pop_vec[issue_lane]);
  assign last_issue = issue && (issue_cnt == CNT_W'(TOTAL_PIXELS - 1));

  assign mem_en   = issue;
  assign mem_rw   = 1'b0;
  assign mem_addr = BASE_ADDR + 32'(issue_cnt);
  assign done     = (state == DONE);

  always_comb begin
    wr_en_vec = '0;
    if (inflight_valid) wr_en_vec[inflight_lane] = 1'b1;
  end

  always_comb begin
    all_drained = (write_cnt == CNT_W'(TOTAL_PIXELS));
    for (int k = 0; k < NUM_LANES; k++) begin
      if (count_arr[k] != '0) all_drained = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      issue_cnt      <= '0;
      write_cnt      <= '0;
      issue_lane     <= '0;
      inflight_lane  <= '0;
      inflight_valid <= 1'b0;
    end else begin
      inflight_valid <= issue;
      if (issue) begin
        inflight_lane <= issue_lane;
        issue_cnt     <= issue_cnt + 1'b1;
        issue_lane    <= issue_lane + 1'b1;
      end
      if (inflight_valid) write_cnt <= write_cnt + 1'b1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= FETCH;
            issue_cnt  <= '0;
            write_cnt  <= '0;
            issue_lane <= '0;
          end
        end
        FETCH:   if (last_issue)  state <= DRAIN;
        DRAIN:   if (all_drained) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en_vec[k]),
      .wr_data (mem_data_in),
      .rd_en   (rd_en_vec[k]),
      .rd_data (rd_data_arr[k]),
      .empty   (empty_vec[k]),
      .full    (full_vec[k]),
      .count   (count_arr[k])
    );
  end

  assign fifo_data_0  = rd_data_arr[0];
  assign fifo_data_1  = rd_data_arr[1];
  assign fifo_data_2  = rd_data_arr[2];
  assign fifo_data_3  = rd_data_arr[3];
  assign fifo_empty_0 = empty_vec[0];
  assign fifo_empty_1 = empty_vec[1];
  assign fifo_empty_2 = empty_vec[2];
  assign fifo_empty_3 = empty_vec[3];

endmodule

// File: tb/tb_image_fetch_distributor.sv
// tb/tb_image_fetch_distributor.sv - scoreboard bench for image_fetch_distributor
module tb_image_fetch_distributor;

  localparam logic [31:0] BASE_A  = 32'h0000_1000;
  localparam logic [31:0] BASE_B  = 32'h0002_0000;
  localparam int          TOTAL_A = 64;
  localparam int          TOTAL_B = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        a_start = 1'b0, b_start = 1'b0;
  logic        a_done, b_done;
  logic [7:0]  a_mem_data_in = 8'h0, b_mem_data_in = 8'h0;
  logic [31:0] a_mem_addr, b_mem_addr;
  logic        a_mem_en, b_mem_en, a_mem_rw, b_mem_rw;
  logic [7:0]  a_data [4];
  logic [7:0]  b_data [4];
  logic [3:0]  a_empty, b_empty;
  logic [3:0]  a_rd_en = 4'h0, b_rd_en = 4'h0;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  logic [31:0] a_addr_q [$];
  int          a_cyc_q  [$];
  logic [7:0]  a_obs [4][$];
  logic [7:0]  b_obs [4][$];
  logic [7:0]  a_exp [4][$];
  logic [7:0]  b_exp [4][$];

  image_fetch_distributor #(
    .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .BASE_ADDR(BASE_A), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .done(a_done),
    .mem_data_in(a_mem_data_in), .mem_addr(a_mem_addr), .mem_en(a_mem_en), .mem_rw(a_mem_rw),
    .fifo_data_0(a_data[0]), .fifo_data_1(a_data[1]), .fifo_data_2(a_data[2]), .fifo_data_3(a_data[3]),
    .fifo_empty_0(a_empty[0]), .fifo_empty_1(a_empty[1]), .fifo_empty_2(a_empty[2]), .fifo_empty_3(a_empty[3]),
    .fifo_rd_en_0(a_rd_en[0]), .fifo_rd_en_1(a_rd_en[1]), .fifo_rd_en_2(a_rd_en[2]), .fifo_rd_en_3(a_rd_en[3])
  );

  image_fetch_distributor #(
    .IMAGE_WIDTH(5), .IMAGE_HEIGHT(3), .BASE_ADDR(BASE_B), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .done(b_done),
    .mem_data_in(b_mem_data_in), .mem_addr(b_mem_addr), .mem_en(b_mem_en), .mem_rw(b_mem_rw),
    .fifo_data_0(b_data[0]), .fifo_data_1(b_data[1]), .fifo_data_2(b_data[2]), .fifo_data_3(b_data[3]),
    .fifo_empty_0(b_empty[0]), .fifo_empty_1(b_empty[1]), .fifo_empty_2(b_empty[2]), .fifo_empty_3(b_empty[3]),
    .fifo_rd_en_0(b_rd_en[0]), .fifo_rd_en_1(b_rd_en[1]), .fifo_rd_en_2(b_rd_en[2]), .fifo_rd_en_3(b_rd_en[3])
  );

  function automatic logic [7:0] pix(int i);
    return 8'((i * 37 + 5) % 256);
  endfunction

  // Byte memories: data returned the cycle after the strobe.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (a_mem_en) a_mem_data_in <= pix(int'(a_mem_addr - BASE_A));
    if (b_mem_en) b_mem_data_in <= pix(int'(b_mem_addr - BASE_B));
  end

  // Observation log: issued addresses and popped pixels.
  always @(negedge clk) begin
    if (a_mem_en) begin
      a_addr_q.push_back(a_mem_addr);
      a_cyc_q.push_back(cycle);
    end
    for (int k = 0; k < 4; k++) begin
      if (a_rd_en[k] && !a_empty[k]) a_obs[k].push_back(a_data[k]);
      if (b_rd_en[k] && !b_empty[k]) b_obs[k].push_back(b_data[k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prep_a();
    a_addr_q.delete();
    a_cyc_q.delete();
    for (int k = 0; k < 4; k++) begin
      a_obs[k].delete();
      a_exp[k].delete();
    end
    for (int i = 0; i < TOTAL_A; i++) a_exp[i % 4].push_back(pix(i));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_rd_en = 4'hF;
    b_rd_en = 4'hF;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", a_done); end
    checks++; if (a_mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0", a_mem_en); end
    checks++; if (a_mem_rw !== 1'b0) begin failures++; $display("FAIL reset_mem_rw got=%b exp=0", a_mem_rw); end
    checks++; if (a_mem_addr !== BASE_A) begin failures++; $display("FAIL reset_mem_addr got=%h exp=%h", a_mem_addr, BASE_A); end
    checks++; if (a_empty !== 4'hF) begin failures++; $display("FAIL reset_empty got=%h exp=f", a_empty); end
    checks++; if ({a_data[0], a_data[1], a_data[2], a_data[3]} !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {a_data[0], a_data[1], a_data[2], a_data[3]});
    end
    checks++; if (b_mem_addr !== BASE_B || b_empty !== 4'hF || b_done !== 1'b0) begin
      failures++; $display("FAIL reset_b got addr=%h empty=%h done=%b exp addr=%h empty=f done=0", b_mem_addr, b_empty, b_done, BASE_B);
    end
  endtask

  task automatic test_idle_reads();
    repeat (5) tick();
    @(negedge clk);
    checks++; if (a_empty !== 4'hF) begin failures++; $display("FAIL idle_empty got=%h exp=f", a_empty); end
    checks++; if (a_obs[0].size() + a_obs[1].size() + a_obs[2].size() + a_obs[3].size() != 0) begin
      failures++; $display("FAIL idle_pops got=%0d exp=0", a_obs[0].size() + a_obs[1].size() + a_obs[2].size() + a_obs[3].size());
    end
    checks++; if (a_addr_q.size() != 0) begin failures++; $display("FAIL idle_reads got=%0d exp=0", a_addr_q.size()); end
  endtask

  task automatic test_full_pass();
    int n = 0;
    int bad = -1;
    prep_a();
    a_rd_en = 4'hF;
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (10) tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    while (!a_done && n < 500) begin tick(); n++; end
    checks++; if (a_done !== 1'b1) begin failures++; $display("FAIL full_pass_done_timeout got=%b exp=1", a_done); end
    repeat (4) tick();
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin failures++; $display("FAIL full_pass_done_held got=%b exp=1", a_done); end
    for (int i = 0; i < a_addr_q.size(); i++) if (bad < 0 && a_addr_q[i] !== BASE_A + 32'(i)) bad = i;
    checks++; if (a_addr_q.size() != TOTAL_A || bad >= 0) begin
      failures++; $display("FAIL full_pass_addr got count=%0d first_bad=%0d exp count=%0d first_bad=-1", a_addr_q.size(), bad, TOTAL_A);
    end
    checks++; if (a_cyc_q.size() != TOTAL_A || a_cyc_q[a_cyc_q.size()-1] - a_cyc_q[0] != TOTAL_A - 1) begin
      failures++; $display("FAIL full_pass_consecutive got span=%0d exp=%0d", a_cyc_q[a_cyc_q.size()-1] - a_cyc_q[0], TOTAL_A - 1);
    end
    for (int k = 0; k < 4; k++) begin
      bad = -1;
      for (int j = 0; j < a_obs[k].size() && j < a_exp[k].size(); j++) if (bad < 0 && a_obs[k][j] !== a_exp[k][j]) bad = j;
      checks++; if (a_obs[k].size() != a_exp[k].size() || bad >= 0) begin
        failures++; $display("FAIL full_pass_lane%0d got size=%0d first_bad=%0d exp size=%0d first_bad=-1", k, a_obs[k].size(), bad, a_exp[k].size());
      end
    end
  endtask

  task automatic test_second_pass();
    int n = 0;
    int bad = -1;
    prep_a();
    a_start = 1'b1; tick(); a_start = 1'b0;
    while (!a_done && n < 500) begin tick(); n++; end
    checks++; if (a_done !== 1'b1) begin failures++; $display("FAIL second_pass_done got=%b exp=1", a_done); end
    for (int i = 0; i < a_addr_q.size(); i++) if (bad < 0 && a_addr_q[i] !== BASE_A + 32'(i)) bad = i;
    checks++; if (a_addr_q.size() != TOTAL_A || bad >= 0) begin
      failures++; $display("FAIL second_pass_addr got count=%0d first_bad=%0d exp count=%0d first_bad=-1", a_addr_q.size(), bad, TOTAL_A);
    end
    for (int k = 0; k < 4; k++) begin
      bad = -1;
      for (int j = 0; j < a_obs[k].size() && j < a_exp[k].size(); j++) if (bad < 0 && a_obs[k][j] !== a_exp[k][j]) bad = j;
      checks++; if (a_obs[k].size() != a_exp[k].size() || bad >= 0) begin
        failures++; $display("FAIL second_pass_lane%0d got size=%0d first_bad=%0d exp size=%0d", k, a_obs[k].size(), bad, a_exp[k].size());
      end
    end
  endtask

  task automatic test_stall();
    prep_a();
    a_rd_en = 4'b1011;
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    checks++; if (a_addr_q.size() != 18) begin failures++; $display("FAIL stall_issue_count got=%0d exp=18", a_addr_q.size()); end
    checks++; if (a_mem_en !== 1'b0) begin failures++; $display("FAIL stall_mem_en got=%b exp=0", a_mem_en); end
    checks++; if (a_mem_addr !== BASE_A + 32'd18) begin failures++; $display("FAIL stall_mem_addr got=%h exp=%h", a_mem_addr, BASE_A + 32'd18); end
    checks++; if (a_empty[2] !== 1'b0 || a_data[2] !== pix(2)) begin
      failures++; $display("FAIL stall_lane2_head got=%h empty=%b exp=%h", a_data[2], a_empty[2], pix(2));
    end
    @(posedge clk); #1; a_rd_en[2] = 1'b1;
    @(negedge clk);
    checks++; if (a_mem_en !== 1'b1 || a_mem_addr !== BASE_A + 32'd18) begin
      failures++; $display("FAIL stall_pop_issue got en=%b addr=%h exp en=1 addr=%h", a_mem_en, a_mem_addr, BASE_A + 32'd18);
    end
    @(posedge clk); #1; a_rd_en[2] = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    checks++; if (a_addr_q.size() != 22 || a_mem_en !== 1'b0) begin
      failures++; $display("FAIL stall_refill got count=%0d en=%b exp count=22 en=0", a_addr_q.size(), a_mem_en);
    end
    checks++; if (a_data[2] !== pix(6) || a_obs[2].size() != 1) begin
      failures++; $display("FAIL stall_lane2_after_pop got head=%h pops=%0d exp head=%h pops=1", a_data[2], a_obs[2].size(), pix(6));
    end
  endtask

  task automatic test_reset_midway();
    int n = 0;
    int bad = -1;
    @(posedge clk); #1; reset = 1'b1;
    tick(); reset = 1'b0;
    prep_a();
    a_rd_en = 4'hF;
    a_start = 1'b1; tick(); a_start = 1'b0;
    while (a_addr_q.size() < 20 && n < 200) begin @(negedge clk); n++; end
    checks++; if (a_addr_q.size() != 20) begin failures++; $display("FAIL midway_reach got=%0d exp=20", a_addr_q.size()); end
    @(posedge clk); #1; reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    checks++; if (a_mem_en !== 1'b0 || a_done !== 1'b0 || a_empty !== 4'hF) begin
      failures++; $display("FAIL midway_reset got en=%b done=%b empty=%h exp en=0 done=0 empty=f", a_mem_en, a_done, a_empty);
    end
    checks++; if ({a_data[0], a_data[1], a_data[2], a_data[3]} !== 32'h0) begin
      failures++; $display("FAIL midway_reset_data got=%h exp=0", {a_data[0], a_data[1], a_data[2], a_data[3]});
    end
    prep_a();
    a_start = 1'b1; tick(); a_start = 1'b0;
    n = 0;
    while (!a_done && n < 500) begin tick(); n++; end
    checks++; if (a_done !== 1'b1 || a_addr_q.size() == 0 || a_addr_q[0] !== BASE_A) begin
      failures++; $display("FAIL midway_refetch got done=%b count=%0d exp done=1 first=%h", a_done, a_addr_q.size(), BASE_A);
    end
    for (int k = 0; k < 4; k++) begin
      bad = -1;
      for (int j = 0; j < a_obs[k].size() && j < a_exp[k].size(); j++) if (bad < 0 && a_obs[k][j] !== a_exp[k][j]) bad = j;
      checks++; if (a_obs[k].size() != a_exp[k].size() || bad >= 0) begin
        failures++; $display("FAIL midway_lane%0d got size=%0d first_bad=%0d exp size=%0d", k, a_obs[k].size(), bad, a_exp[k].size());
      end
    end
  endtask

  task automatic test_remainder();
    int n = 0;
    int bad;
    for (int k = 0; k < 4; k++) begin
      b_obs[k].delete();
      b_exp[k].delete();
    end
    for (int i = 0; i < TOTAL_B; i++) b_exp[i % 4].push_back(pix(i));
    b_rd_en = 4'b0111;
    b_start = 1'b1; tick(); b_start = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    checks++; if (b_done !== 1'b0 || b_empty[3] !== 1'b0) begin
      failures++; $display("FAIL remainder_hold got done=%b empty3=%b exp done=0 empty3=0", b_done, b_empty[3]);
    end
    @(posedge clk); #1; b_rd_en = 4'hF;
    while (!b_done && n < 200) begin tick(); n++; end
    checks++; if (b_done !== 1'b1 || b_empty !== 4'hF) begin
      failures++; $display("FAIL remainder_done got done=%b empty=%h exp done=1 empty=f", b_done, b_empty);
    end
    for (int k = 0; k < 4; k++) begin
      bad = -1;
      for (int j = 0; j < b_obs[k].size() && j < b_exp[k].size(); j++) if (bad < 0 && b_obs[k][j] !== b_exp[k][j]) bad = j;
      checks++; if (b_obs[k].size() != ((k < 3) ? 4 : 3) || b_obs[k].size() != b_exp[k].size() || bad >= 0) begin
        failures++; $display("FAIL remainder_lane%0d got size=%0d first_bad=%0d exp size=%0d", k, b_obs[k].size(), bad, (k < 3) ? 4 : 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_reads();
    test_full_pass();
    test_second_pass();
    test_stall();
    test_reset_midway();
    test_remainder();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
